// File: rtl/alu_pkg.sv
// Shared ALU package: datapath widths, divider state encoding and ALU opcodes.
// Used by the combinational ALU, its controller and the sequential divider.
package alu_pkg;

  localparam int DIV_NW = 8;
  localparam int DIV_DW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // OP_DIV is reserved so the controller can route a divide to seq_div.
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_MULT2 = 4'h5;
  localparam logic [3:0] OP_DIV   = 4'h6;

  function automatic int cnt_width(input int iterations);
    return $clog2(iterations + 1);
  endfunction

endpackage

// File: rtl/seq_div_if.sv
// Start/done handshake and operand/result bus between the controller and seq_div.
interface seq_div_if import alu_pkg::*; #(
  parameter int NW = DIV_NW,
  parameter int DW = DIV_DW
);

  logic          start;
  logic [NW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [NW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, subtract the divisor if it fits, emit one quotient bit.
module div_step import alu_pkg::*; #(
  parameter int NW = DIV_NW,
  parameter int DW = DIV_DW
) (
  input  logic [DW:0]   p,
  input  logic [NW-1:0] q,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   p_next,
  output logic [NW-1:0] q_next
);

  logic [DW:0] shifted;
  logic        fits;
  logic        unused_p_msb;

  // The MSB of P is always shifted out, so only P[DW-1:0] carries information.
  assign unused_p_msb = p[DW];

  assign shifted = {p[DW-1:0], q[NW-1]};
  assign fits    = (shifted >= {1'b0, divisor});
  assign p_next  = fits ? (shifted - {1'b0, divisor}) : shifted;
  assign q_next  = {q[NW-2:0], fits};

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Optional DIV_ZERO_SHORTCUT_EN: a zero divisor skips iteration and flags div_by_zero.
module seq_div import alu_pkg::*; #(
  parameter int NW = DIV_NW,
  parameter int DW = DIV_DW
) (
  input  logic     clk,
  input  logic     rst,
  seq_div_if.slave bus
);

  localparam int CW = cnt_width(NW);

  div_state_e    state;
  div_state_e    state_next;
  logic [CW-1:0] cnt;
  logic [DW:0]   p_reg;
  logic [DW:0]   p_step;
  logic [NW-1:0] q_reg;
  logic [NW-1:0] q_step;
  logic [DW-1:0] dvs_reg;
  logic [NW-1:0] quot_reg;
  logic [DW-1:0] rem_reg;
  logic          dbz_reg;
  logic          accept;
  logic          finish;
  logic          zero_div;

  div_step #(
    .NW(NW),
    .DW(DW)
  ) u_step (
    .p       (p_reg),
    .q       (q_reg),
    .divisor (dvs_reg),
    .p_next  (p_step),
    .q_next  (q_step)
  );

`ifdef DIV_ZERO_SHORTCUT_EN
  assign zero_div = (bus.divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A new start is honoured in DONE as well as IDLE, giving back-to-back operation.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = zero_div ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      p_reg    <= '0;
      q_reg    <= '0;
      dvs_reg  <= '0;
      quot_reg <= '0;
      rem_reg  <= '0;
      dbz_reg  <= 1'b0;
    end else begin
      dbz_reg <= 1'b0;
      if (accept) begin
        dvs_reg <= bus.divisor;
        q_reg   <= bus.dividend;
        p_reg   <= '0;
        if (zero_div) begin
          cnt      <= '0;
          quot_reg <= '1;
          rem_reg  <= bus.dividend[DW-1:0];
          dbz_reg  <= 1'b1;
        end else begin
          cnt <= CW'(NW);
        end
      end else if (state == RUN) begin
        p_reg <= p_step;
        q_reg <= q_step;
        cnt   <= cnt - CW'(1);
        // Results are published only on the final step so they hold across the next run.
        if (finish) begin
          quot_reg <= q_step;
          rem_reg  <= p_step[DW-1:0];
        end
      end
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quot_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed handshake cases plus random operands
// compared against an arithmetic reference (plain / and %).
module tb_seq_div;
  import alu_pkg::*;

  localparam int NW = DIV_NW;
  localparam int DW = DIV_DW;

`ifdef DIV_ZERO_SHORTCUT_EN
  localparam bit SHORTCUT = 1'b1;
`else
  localparam bit SHORTCUT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  seq_div_if #(.NW(NW), .DW(DW)) bus ();

  seq_div #(
    .NW(NW),
    .DW(DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result straight from the arithmetic definition of division.
  function automatic void refDiv(input logic [NW-1:0] a, input logic [DW-1:0] d,
                                 output logic [NW-1:0] q, output logic [DW-1:0] r,
                                 output logic z, output int lat);
    if (d == '0) begin
      q   = '1;
      r   = a[DW-1:0];
      z   = SHORTCUT;
      lat = SHORTCUT ? 1 : NW + 1;
    end else begin
      q   = a / NW'(d);
      r   = DW'(a % NW'(d));
      z   = 1'b0;
      lat = NW + 1;
    end
  endfunction

  task automatic applyStimulus(input logic [NW-1:0] a, input logic [DW-1:0] d, input bit hold);
    bus.dividend = a;
    bus.divisor  = d;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  // Called #1 into cycle fromCyc; returns at the negedge of the done cycle.
  task automatic waitForDone(input int fromCyc, input string tag, output int doneCyc);
    bit seen;
    seen    = 1'b0;
    doneCyc = -1;
    for (int c = fromCyc; c <= 24 && !seen; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        doneCyc = c;
        seen    = 1'b1;
      end else begin
        checkOutput({tag, ".busy_run"}, 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Checks the done cycle, then steps #1 past the next rising edge.
  task automatic checkResult(input string tag, input logic [NW-1:0] a,
                             input logic [DW-1:0] d, input int doneCyc);
    logic [NW-1:0] eq;
    logic [DW-1:0] er;
    logic          ez;
    int            lat;
    refDiv(a, d, eq, er, ez, lat);
    checkOutput({tag, ".latency"}, 32'(doneCyc), 32'(lat));
    checkOutput({tag, ".busy_done"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, ".quotient"}, 32'(bus.quotient), 32'(eq));
    checkOutput({tag, ".remainder"}, 32'(bus.remainder), 32'(er));
    checkOutput({tag, ".dbz"}, 32'(bus.div_by_zero), 32'(ez));
    @(posedge clk);
    #1;
  endtask

  task automatic runOp(input string tag, input logic [NW-1:0] a, input logic [DW-1:0] d);
    int c;
    applyStimulus(a, d, 1'b0);
    waitForDone(1, tag, c);
    checkResult(tag, a, d, c);
  endtask

  initial begin
    int c;
    logic [NW-1:0] ra;
    logic [DW-1:0] rd;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.busy", 32'(bus.busy), 32'd0);
    checkOutput("reset.done", 32'(bus.done), 32'd0);
    checkOutput("reset.quotient", 32'(bus.quotient), 32'd0);
    checkOutput("reset.remainder", 32'(bus.remainder), 32'd0);
    checkOutput("reset.dbz", 32'(bus.div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    runOp("d200_7", 8'd200, 4'd7);
    runOp("d255_15", 8'd255, 4'd15);
    runOp("d5_9", 8'd5, 4'd9);
    runOp("dA5_0", 8'hA5, 4'd0);

    // A start pulse mid-run must not disturb the operation in flight.
    applyStimulus(8'd100, 4'd3, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.dividend = 8'd50;
    bus.divisor  = 4'd5;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitForDone(5, "ignore", c);
    checkResult("ignore", 8'd100, 4'd3, c);

    // Reset mid-run discards the result and clears all outputs.
    applyStimulus(8'd200, 4'd7, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst.busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst.done", 32'(bus.done), 32'd0);
    checkOutput("midrst.quotient", 32'(bus.quotient), 32'd0);
    checkOutput("midrst.remainder", 32'(bus.remainder), 32'd0);
    checkOutput("midrst.dbz", 32'(bus.div_by_zero), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("midrst.idle_done", 32'(bus.done), 32'd0);
    end
    @(posedge clk);
    #1;
    runOp("d9_2", 8'd9, 4'd2);

    // Start held high into the done cycle launches the next operation there.
    applyStimulus(8'd12, 4'd4, 1'b1);
    bus.dividend = 8'd13;
    waitForDone(1, "b2b_first", c);
    checkResult("b2b_first", 8'd12, 4'd4, c);
    bus.start = 1'b0;
    waitForDone(1, "b2b_second", c);
    checkResult("b2b_second", 8'd13, 4'd4, c);

    for (int i = 0; i < 24; i++) begin
      ra = NW'($urandom_range(0, 255));
      rd = (i % 6 == 0) ? '0 : DW'($urandom_range(1, 15));
      runOp("random", ra, rd);
    end

    $display("[TB] random and directed cases complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
